// File: rtl/vga_fb_write_responder.sv
// Framebuffer store/load responder: buffers processor stores and drains them to frame RAM in blanking.
// Optional ordered read-back path is compiled in with FB_READBACK_EN.
module vga_fb_write_responder #(
    parameter logic [31:0] FB_BASE    = 32'h0010_0000,
    parameter int unsigned FB_PIXELS  = 307200,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic [31:0]                   addr_in,
    input  logic [31:0]                   data_in,
    input  logic                          wr_en_in,
    input  logic                          rd_en_in,
    output logic [31:0]                   rd_data_out,
    output logic                          rd_valid_out,
    output logic                          busy_out,
    input  logic                          blank_n_in,
    output logic [ADDR_W-1:0]             ram_addr_out,
    output logic [DATA_W-1:0]             ram_wdata_out,
    output logic                          ram_we_out,
    input  logic [DATA_W-1:0]             ram_rdata_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic [15:0]                   drop_count_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

`ifdef FB_READBACK_EN
    typedef enum logic [1:0] {StIdle, StWrite, StRdAddr, StRdData} state_e;
`else
    typedef enum logic [0:0] {StIdle, StWrite} state_e;
`endif

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [15:0]        drop_q;
    logic               busy_q;
    logic               full_d;

    logic [31:0]        offset_full;
    logic [ADDR_W-1:0]  offset;
    logic               hit;
    logic               empty, full;
    logic               pop, push, drop;
    logic               unused_bits;

    assign offset_full = addr_in - FB_BASE;
    assign offset      = offset_full[ADDR_W-1:0];
    assign hit         = (addr_in >= FB_BASE) && (offset_full < FB_PIXELS);

    assign empty = (count_q == '0);
    assign full  = (count_q == LVL_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a store on a full FIFO still lands.
    assign pop   = (state_q == StWrite) && !empty;
    assign push  = wr_en_in && hit && (!full || pop);
    assign drop  = wr_en_in && hit && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    assign full_d = (count_d == LVL_W'(FIFO_DEPTH));

`ifdef FB_READBACK_EN
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  ld_off_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic               ld_take, ld_hit, ld_miss;

    // Any load seen while one is pending is ignored, hit or miss.
    assign ld_take = rd_en_in && !pend_q;
    assign ld_hit  = ld_take && hit;
    assign ld_miss = ld_take && !hit;
    assign pend_d  = (pend_q && (state_q != StRdData)) || ld_hit;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pend_q     <= 1'b0;
            ld_off_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            rd_valid_q <= (state_q == StRdData) || ld_miss;
            rd_data_q  <= (state_q == StRdData) ? ram_rdata_in : '0;
            if (ld_hit) begin
                ld_off_q <= offset;
            end
        end
    end

    assign rd_data_out  = {{(32 - DATA_W){1'b0}}, rd_data_q};
    assign rd_valid_out = rd_valid_q;
    assign unused_bits  = ^{data_in[31:DATA_W], offset_full[31:ADDR_W]};
`else
    assign rd_data_out  = '0;
    assign rd_valid_out = 1'b0;
    assign unused_bits  = ^{data_in[31:DATA_W], offset_full[31:ADDR_W], rd_en_in, ram_rdata_in};
`endif

    // Decisions look at next-cycle occupancy so a store or load accepted now is served next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!blank_n_in && (count_d != '0)) begin
                    state_d = StWrite;
`ifdef FB_READBACK_EN
                end else if (!blank_n_in && pend_d) begin
                    state_d = StRdAddr;
`endif
                end
            end
            StWrite: begin
                if ((count_d == '0) || blank_n_in) begin
                    state_d = StIdle;
                end
            end
`ifdef FB_READBACK_EN
            StRdAddr: state_d = StRdData;
            StRdData: state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_we_out    = pop;
        ram_addr_out  = '0;
        ram_wdata_out = '0;
        if (pop) begin
            {ram_addr_out, ram_wdata_out} = mem[rd_ptr_q];
        end
`ifdef FB_READBACK_EN
        if (state_q == StRdAddr) begin
            ram_addr_out = ld_off_q;
        end
`endif
    end

    always_ff @(posedge iVGA_CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= {offset, data_in[DATA_W-1:0]};
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
`ifdef FB_READBACK_EN
            busy_q <= full_d | pend_d;
`else
            busy_q <= full_d;
`endif
        end
    end

    assign busy_out       = busy_q;
    assign fifo_level_out = count_q;
    assign drop_count_out = drop_q;

endmodule
